syn_counter_4bit: RTL and testbench

//   Free-running 4-bit synchronous up-counter. All flip-flops share the single

---
 rtl/syn_counter_4bit.sv | 21 ++
 tb/tb_syn_counter_4bit.sv | 52 +++++
 2 files changed

// File: rtl/syn_counter_4bit.sv
// syn_counter_4bit: free-running synchronous up-counter built as a T-flip-flop chain with an AND carry chain
module syn_counter_4bit #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clki,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);
   // Declaration value gives the configuration-time start, so counting begins at RST_VAL without a reset
   logic [WIDTH-1:0] cnt = RST_VAL;
   logic [WIDTH-1:0] t;
   assign t[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_carry
      assign t[i] = t[i-1] & cnt[i-1];
   end
   always_ff @(posedge clki) begin
      cnt <= reset ? RST_VAL : cnt ^ t;
   end
   assign q = cnt;
endmodule

// File: tb/tb_syn_counter_4bit.sv
// tb_syn_counter_4bit: directed and randomized checks of the 4-bit counter against a modulo-16 reference
module tb_syn_counter_4bit;
   logic       clki = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] q;
   int         total = 0;
   int         bad = 0;
   int         exp_cnt = 0;

   syn_counter_4bit dut (.clki(clki), .reset(reset), .q(q));

   always #20 clki = ~clki;

   task automatic check(input string tag);
      logic [3:0] e;
      e = 4'(exp_cnt);
      total++;
      assert (q === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, q, e);
      end
   endtask

   // Drive reset, take one rising edge, update the reference, check on the falling edge
   task automatic step(input logic r, input string tag);
      reset = r;
      @(posedge clki);
      exp_cnt = r ? 0 : (exp_cnt + 1) % 16;
      @(negedge clki);
      check(tag);
   endtask

   initial begin
      #1;
      check("powerup");
      for (int i = 0; i < 5; i++) step(1'b0, "count_from_powerup");
      for (int i = 0; i < 3; i++) step(1'b1, "reset_held");
      for (int i = 0; i < 20; i++) step(1'b0, "release_and_wrap");
      while (exp_cnt != 15) step(1'b0, "run_to_f");
      step(1'b1, "reset_at_f");
      step(1'b0, "first_after_reset");
      for (int i = 0; i < 3; i++) begin
         #5 reset = 1'b1;
         #5 reset = 1'b0;
         check("pulse_between_edges");
         step(1'b0, "after_pulse");
      end
      for (int i = 0; i < 200; i++) step(($urandom_range(0, 7) == 0), "random");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
